// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the half-precision arithmetic units:
// field widths, canonical encodings, integer limits and the converter FSM state type.
package fp16_pkg;
  localparam int FP_W   = 16;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int INT_W  = 16;
  localparam int WORK_W = 26;
  localparam int BIAS   = 15;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  localparam logic [FP_W-1:0] QNAN    = 16'h7E00;
  localparam logic [FP_W-1:0] POS_INF = 16'h7C00;
  localparam logic [FP_W-1:0] NEG_INF = 16'hFC00;

  localparam logic [INT_W-1:0] INT16_MAX  = 16'h7FFF;
  localparam logic [INT_W-1:0] INT16_MIN  = 16'h8000;
  localparam logic [INT_W-1:0] UINT16_MAX = 16'hFFFF;

  typedef struct packed {
    logic              sign;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
    logic              is_sub;
    logic [5:0]        exp;   // unbiased, two's complement; subnormals report 1-BIAS
    logic [MAN_W:0]    mant;  // hidden bit included
  } fp16_class_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_SHIFT,
    S_PACK,
    S_DONE
  } state_t;
endpackage

// File: rtl/fp16_to_int_if.sv
// start/done handshake bundle for the fp16 -> int16 converter.
interface fp16_to_int_if;
  logic        start;
  logic        is_unsigned;
  logic [15:0] in_a;
  logic [15:0] out;
  logic        done;
  logic        flag_invalid;
  logic        flag_inexact;

  modport master (output start, is_unsigned, in_a,
                  input  out, done, flag_invalid, flag_inexact);
  modport slave  (input  start, is_unsigned, in_a,
                  output out, done, flag_invalid, flag_inexact);
endinterface

// File: rtl/fp16_classify.sv
// Combinational fp16 field decode: special-value classes, unbiased exponent
// and mantissa with hidden bit. Shared with the add/sub unit.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [FP_W-1:0] a,
  output fp16_class_t     cls
);
  logic [EXP_W-1:0] e_fld;
  logic [MAN_W-1:0] f_fld;

  assign e_fld = a[14:10];
  assign f_fld = a[9:0];

  always_comb begin
    cls         = '0;
    cls.sign    = a[15];
    cls.is_nan  = (e_fld == EXP_MAX) && (f_fld != '0);
    cls.is_inf  = (e_fld == EXP_MAX) && (f_fld == '0);
    cls.is_zero = (e_fld == '0) && (f_fld == '0);
    cls.is_sub  = (e_fld == '0) && (f_fld != '0);
    // subnormals share the exponent of the smallest normal
    cls.exp     = {1'b0, (e_fld == '0) ? 5'd1 : e_fld} - 6'(BIAS);
    cls.mant    = {e_fld != '0, f_fld};
  end
endmodule

// File: rtl/fp16_to_int.sv
// Multi-cycle fp16 -> int16/uint16 converter, round toward zero, saturating,
// with invalid/inexact flags. Magnitude is built by a one-bit-per-cycle shifter.
module fp16_to_int
  import fp16_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fp16_to_int_if.slave  bus
);
  state_t            state, state_nxt;
  logic [FP_W-1:0]   a_q;
  logic              uns_q;
  logic [WORK_W-1:0] work;
  logic [4:0]        cnt;
  logic [INT_W-1:0]  out_q;
  logic              inv_q, inx_q, done_q;

  fp16_class_t       cls;

  logic              early;
  logic [INT_W-1:0]  early_out;
  logic              early_inv, early_inx;
  logic [INT_W-1:0]  mag, pack_out;

  fp16_classify u_cls (.a(a_q), .cls(cls));

  // Every result not needing the shifter is resolved in DEC.
  always_comb begin
    early     = 1'b1;
    early_out = '0;
    early_inv = 1'b0;
    early_inx = 1'b0;
    if (cls.is_nan) begin
      early_out = uns_q ? UINT16_MAX : INT16_MAX;
      early_inv = 1'b1;
    end else if (cls.is_inf) begin
      if (cls.sign) early_out = uns_q ? 16'h0000 : INT16_MIN;
      else          early_out = uns_q ? UINT16_MAX : INT16_MAX;
      early_inv = 1'b1;
    end else if (cls.is_zero) begin
      early_out = '0;
    end else if (cls.is_sub || cls.exp[5]) begin
      early_inx = 1'b1;
    end else if (uns_q && cls.sign) begin
      early_inv = 1'b1;
    end else if (!uns_q && (cls.exp[4:0] >= 5'd15)) begin
      if (cls.sign && (cls.mant == 11'h400)) begin
        early_out = INT16_MIN;
      end else begin
        early_out = cls.sign ? INT16_MIN : INT16_MAX;
        early_inv = 1'b1;
      end
    end else begin
      early = 1'b0;
    end
  end

  assign mag      = work[WORK_W-1:MAN_W];
  assign pack_out = (!uns_q && a_q[15]) ? -mag : mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE,
      S_DONE:  state_nxt = bus.start ? S_DEC : S_IDLE;
      S_DEC:   state_nxt = early ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt == '0) state_nxt = S_PACK;
      S_PACK:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      uns_q  <= 1'b0;
      work   <= '0;
      cnt    <= '0;
      out_q  <= '0;
      inv_q  <= 1'b0;
      inx_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_nxt == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q   <= bus.in_a;
            uns_q <= bus.is_unsigned;
          end
        end
        S_DEC: begin
          if (early) begin
            out_q <= early_out;
            inv_q <= early_inv;
            inx_q <= early_inx;
          end else begin
            work <= {15'b0, cls.mant};
            cnt  <= cls.exp[4:0];
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            work <= work << 1;
            cnt  <= cnt - 5'd1;
          end
        end
        S_PACK: begin
          out_q <= pack_out;
          inv_q <= 1'b0;
          inx_q <= (work[MAN_W-1:0] != '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.out          = out_q;
  assign bus.done         = done_q;
  assign bus.flag_invalid = inv_q;
  assign bus.flag_inexact = inx_q;
endmodule

// File: tb/tb_fp16_to_int.sv
// Scoreboard bench for fp16_to_int: expected results queued at start,
// checked (value, flags, latency) when done pulses.
module tb_fp16_to_int;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] out;
    logic        inv;
    logic        inx;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];

  fp16_to_int_if bus();

  fp16_to_int dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("out[%h]", e.a), bus.out, e.out);
        chk($sformatf("inv[%h]", e.a), bus.flag_invalid, e.inv);
        chk($sformatf("inx[%h]", e.a), bus.flag_inexact, e.inx);
        chk($sformatf("lat[%h]", e.a), cyc - e.issue + 1, e.lat);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic u);
    bus.in_a = a; bus.is_unsigned = u; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic convert(input logic [15:0] a, input logic u, input logic [15:0] eo,
                         input logic ei, input logic ex, input int el);
    sb.push_back('{a, eo, ei, ex, el, cyc + 1});
    pulse_start(a, u);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.is_unsigned = 1'b0; bus.in_a = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", bus.out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_flags", {bus.flag_invalid, bus.flag_inexact}, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    //       a         uns   out      inv  inx  edge
    convert(16'h4A40, 1'b0, 16'h000C, 1'b0, 1'b1, 7);
    convert(16'hC500, 1'b0, 16'hFFFB, 1'b0, 1'b0, 6);
    convert(16'h3C00, 1'b0, 16'h0001, 1'b0, 1'b0, 4);
    convert(16'hF800, 1'b0, 16'h8000, 1'b0, 1'b0, 2);
    convert(16'h7800, 1'b0, 16'h7FFF, 1'b1, 1'b0, 2);
    convert(16'h7BFF, 1'b1, 16'hFFE0, 1'b0, 1'b0, 19);
    convert(16'hBC00, 1'b1, 16'h0000, 1'b1, 1'b0, 2);
    convert(16'hB800, 1'b1, 16'h0000, 1'b0, 1'b1, 2);
    convert(16'h7E00, 1'b0, 16'h7FFF, 1'b1, 1'b0, 2);
    convert(16'hFC00, 1'b0, 16'h8000, 1'b1, 1'b0, 2);
    convert(16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 2);
    convert(16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 2);
    convert(16'h7E00, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2);
    convert(16'h7C00, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2);
    convert(16'hFC00, 1'b1, 16'h0000, 1'b1, 1'b0, 2);
    convert(16'h77FF, 1'b0, 16'h7FF0, 1'b0, 1'b0, 18);
    convert(16'hF7FF, 1'b0, 16'h8010, 1'b0, 1'b0, 18);
    convert(16'hFBFF, 1'b0, 16'h8000, 1'b1, 1'b0, 2);
    convert(16'h3E00, 1'b1, 16'h0001, 1'b0, 1'b1, 4);

    // start during SHIFT must be ignored: one done, first operand's result
    sb.push_back('{16'h4A40, 16'h000C, 1'b0, 1'b1, 7, cyc + 1});
    pulse_start(16'h4A40, 1'b0);
    repeat (2) @(negedge clk);
    #1 pulse_start(16'h3C00, 1'b0);
    wait_idle();
    repeat (25) @(negedge clk);
    #1;

    // reset mid-SHIFT aborts with no done and clears the outputs
    pulse_start(16'h4A40, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", bus.out, 0);
    chk("abort_flags", {bus.flag_invalid, bus.flag_inexact}, 0);
    chk("abort_done", bus.done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    chk("post_abort_out", bus.out, 0);
    convert(16'h4A40, 1'b0, 16'h000C, 1'b0, 1'b1, 7);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fp16_to_int.md
Name: fp16_to_int

Overview:
- Multi-cycle converter from IEEE 754 half-precision (fp16) to a 16-bit integer. It decodes a packed fp16 operand into a signed or unsigned int16.
- Rounds toward zero, which matches the truncating pack used by the fp16 add/sub unit.
- Saturates on overflow and reports invalid/inexact flags.
- Sits beside the fp16 arithmetic units on the same start/done handshake and feeds integer datapaths.

Parameters:
- None. Formats are fixed: fp16 in, 16-bit integer out.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin conversion; sampled only in IDLE
- is_unsigned  in  1  0: signed int16 result, 1: unsigned uint16 result; captured with start
- in_a  in  16  fp16 operand; captured with start
- out  out  16  integer result; holds until next result is written
- done  out  1  one-cycle pulse, result valid
- flag_invalid  out  1  NaN, Inf, or out-of-range; valid with done, held
- flag_inexact  out  1  discarded nonzero fraction bits; valid with done, held

Behaviour:
- Reset:
  - out=0, done=0, both flags=0, state=IDLE, all work registers cleared.
  - Reset mid-operation aborts the conversion with no done pulse.
- Fields: s=in_a[15], E=in_a[14:10], f=in_a[9:0]. Unbiased exponent e=E-15. Mantissa m={E!=0, f}.
- States:
  - IDLE: on start, capture in_a and is_unsigned, go to DEC. start is ignored in every other state.
  - DEC classifies the operand, in priority order. Each row below writes out and the flags, then goes to DONE:
    - NaN: out = signed ? 0x7FFF : 0xFFFF; invalid=1.
    - +Inf: out = 0x7FFF signed / 0xFFFF unsigned; invalid=1.
    - -Inf: out = 0x8000 signed / 0x0000 unsigned; invalid=1.
    - Zero (either sign): out=0; no flags.
    - E<15 (|x|<1, includes subnormals): out=0; inexact=1.
    - Unsigned and s=1 (|x|>=1): out=0; invalid=1.
    - Signed, E>=30 (|x|>=32768):
      - exactly -32768 (0xF800): out=0x8000, no flags;
      - otherwise: out = s ? 0x8000 : 0x7FFF; invalid=1.
  - DEC, all other cases: load 26-bit work={15'b0, m} (value x 2^10) and cnt=e, then go to SHIFT. The shift range is e<=14 signed, e<=15 unsigned.
  - SHIFT: while cnt!=0, work<<=1 and cnt-=1. When cnt==0, go to PACK.
  - PACK:
    - int=work[25:10]; inexact=(work[9:0]!=0); invalid=0.
    - out = (signed && s) ? -int : int (two's complement, 16-bit wrap is never reached).
    - Go to DONE.
  - DONE: done<=1 for one cycle, return to IDLE.
- Latency, counting from the edge that samples start:
  - done is high after edge 2 on the early-exit paths.
  - done is high after edge e+4 on the shift path; maximum 19.
- Next start is accepted in the cycle done is high.
- Range guarantees:
  - Signed magnitude on the shift path is at most 32752.
  - Unsigned maximum is 65504 (0xFFE0); positive unsigned overflow is impossible except Inf.

Decomposition:
- Shared package fp16_pkg holds:
  - field widths, BIAS=15, EXP_MAX=5'h1F;
  - canonical encodings: QNAN=16'h7E00, POS_INF, NEG_INF;
  - INT16_MAX/MIN and UINT16_MAX;
  - the FSM state typedef.
- One natural sub-module, fp16_classify: combinational is_nan/is_inf/is_zero/is_sub plus the adjusted exponent and 11-bit mantissa. It is reusable by the add/sub unit.

Test Plan:
- 0x4A40 (12.5), signed -> out=0x000C, inexact=1, invalid=0; done after edge 7 (e=3).
- 0xC500 (-5.0), signed -> 0xFFFB, no flags. 0x3C00 (1.0), signed -> 0x0001, no flags, done after edge 4.
- 0xF800, signed -> 0x8000, no flags. 0x7800 (+32768), signed -> 0x7FFF, invalid=1, done after edge 2.
- 0x7BFF (65504), unsigned -> 0xFFE0, no flags, done after edge 19. 0xBC00 (-1.0), unsigned -> 0x0000, invalid=1. 0xB800 (-0.5), unsigned -> 0x0000, inexact=1.
- Specials, signed:
  - 0x7E00 -> 0x7FFF, invalid;
  - 0xFC00 -> 0x8000, invalid;
  - 0x0001 -> 0x0000, inexact;
  - 0x8000 -> 0x0000, no flags.
- Handshake:
  - Pulse start again during SHIFT -> ignored, one done only.
  - Assert rst_n low mid-SHIFT -> out/flags=0, no done.
  - A following 0x4A40 converts correctly.
